// File: rtl/maxpool_downsampling_pkg.sv
// Shared types, sizes and the lane-wise signed max used by the 2x2 stride-2 max-pool block.
`ifndef AXI_WIDTH_DATA_IN
`define AXI_WIDTH_DATA_IN 256
`endif

package maxpool_downsampling_pkg;
    localparam int LANES                 = 16;
    localparam int LANE_W                = 16;
    localparam int DATA_W                = `AXI_WIDTH_DATA_IN;
    localparam int WIDTH_FEATURE_SIZE    = 11;
    localparam int WIDTH_CHANNEL_NUM_REG = 10;
    localparam int MAX_GROUPS            = 64;
    localparam int LINE_DEPTH            = 2048;
    localparam int GROUP_W               = $clog2(MAX_GROUPS);
    localparam int LINE_AW               = $clog2(LINE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pool_state_e;

    function automatic logic [DATA_W-1:0] lane_max(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            if ($signed(a[i*LANE_W +: LANE_W]) > $signed(b[i*LANE_W +: LANE_W])) begin
                res[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W];
            end else begin
                res[i*LANE_W +: LANE_W] = b[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/maxpool_downsampling_line_buffer.sv
// Simple dual-port RAM with synchronous, enable-gated read; holds its read data while re is low.
module pool_line_buffer
    import maxpool_downsampling_pkg::*;
#(
    parameter int DEPTH = LINE_DEPTH,
    parameter int AW    = LINE_AW,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_r [DEPTH];

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end
endmodule

// File: rtl/maxpool_downsampling.sv
// Streaming 2x2 stride-2 max-pool: horizontal pairs via pair_buf, vertical pairs via line_buf.
module maxpool_downsampling
    import maxpool_downsampling_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Start,
    input  logic                             Next_Reg,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_In_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Col_Num_In_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_In_Num_REG,
    input  logic [DATA_W-1:0]                S_Data,
    input  logic                             S_Valid,
    output logic                             S_Ready,
    output logic [DATA_W-1:0]                M_Data,
    output logic                             M_Valid,
    input  logic                             M_Ready,
    output logic                             Last_Pool,
    output logic                             Pool_Complete
);
    pool_state_e state_r, state_n;

    logic [WIDTH_FEATURE_SIZE-1:0]    h_cfg_r, w_cfg_r, r_r, c_r, ocol_r, orow_r;
    logic [WIDTH_FEATURE_SIZE-1:0]    half_h_s, half_w_s;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] g_cfg_r, oc_r;
    logic [GROUP_W-1:0]               g_r;
    logic [LINE_AW-1:0]               base_r, lb_addr_s, s1_addr_r;
    logic                             start_s, advance_s, accept_s, last_in_s, done_s;
    logic                             g_last_s, col_last_s, row_last_s;
    logic                             s1_valid_r, s1_odd_col_r, s1_odd_row_r, s2_emit_r;
    logic                             m_valid_r, pool_complete_r;
    logic [DATA_W-1:0]                s1_data_r, s2_h_r, m_data_r;
    logic [DATA_W-1:0]                pair_rdata_s, line_rdata_s, h_s, v_s;
    logic                             pair_we_s, line_we_s;

    assign start_s    = Start && (state_r == ST_IDLE);
    assign advance_s  = !m_valid_r || M_Ready;
    assign S_Ready    = (state_r == ST_RUN) && advance_s;
    assign accept_s   = S_Valid && S_Ready;
    assign g_last_s   = (WIDTH_CHANNEL_NUM_REG'(g_r) == g_cfg_r - 10'd1);
    assign col_last_s = (c_r == w_cfg_r - 11'd1);
    assign row_last_s = (r_r == h_cfg_r - 11'd1);
    assign last_in_s  = accept_s && g_last_s && col_last_s && row_last_s;
    assign lb_addr_s  = base_r + LINE_AW'(g_r);
    assign half_h_s   = h_cfg_r >> 1;
    assign half_w_s   = w_cfg_r >> 1;

    // Final beat gone and both stages empty: the map is finished.
    assign done_s = (state_r == ST_DRAIN) && !s1_valid_r && !s2_emit_r && (!m_valid_r || M_Ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE:  if (start_s)   state_n = ST_RUN;   else state_n = ST_IDLE;
            ST_RUN:   if (last_in_s) state_n = ST_DRAIN; else state_n = ST_RUN;
            ST_DRAIN: if (done_s)    state_n = ST_IDLE;  else state_n = ST_DRAIN;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Config latch and input-side group/column/row counters; base_r tracks (c>>1)*G.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cfg_r <= '0;
            w_cfg_r <= '0;
            g_cfg_r <= '0;
            g_r     <= '0;
            c_r     <= '0;
            r_r     <= '0;
            base_r  <= '0;
        end else if (start_s) begin
            h_cfg_r <= Row_Num_In_REG;
            w_cfg_r <= Col_Num_In_REG;
            g_cfg_r <= Channel_In_Num_REG >> 4;
            g_r     <= '0;
            c_r     <= '0;
            r_r     <= '0;
            base_r  <= '0;
        end else if (accept_s) begin
            if (g_last_s) begin
                g_r <= '0;
                if (col_last_s) begin
                    c_r    <= '0;
                    base_r <= '0;
                    r_r    <= row_last_s ? 11'd0 : r_r + 11'd1;
                end else begin
                    c_r <= c_r + 11'd1;
                    if (c_r[0]) begin
                        base_r <= base_r + LINE_AW'(g_cfg_r);
                    end
                end
            end else begin
                g_r <= g_r + 6'd1;
            end
        end
    end

    assign pair_we_s = accept_s && !c_r[0];
    assign h_s       = lane_max(pair_rdata_s, s1_data_r);
    assign line_we_s = advance_s && s1_valid_r && s1_odd_col_r && !s1_odd_row_r;
    assign v_s       = lane_max(line_rdata_s, s2_h_r);

    pool_line_buffer #(.DEPTH(MAX_GROUPS), .AW(GROUP_W), .DW(DATA_W)) u_pair_buf (
        .clk   (clk),
        .we    (pair_we_s),
        .waddr (g_r),
        .wdata (S_Data),
        .re    (advance_s),
        .raddr (g_r),
        .rdata (pair_rdata_s)
    );

    pool_line_buffer #(.DEPTH(LINE_DEPTH), .AW(LINE_AW), .DW(DATA_W)) u_line_buf (
        .clk   (clk),
        .we    (line_we_s),
        .waddr (s1_addr_r),
        .wdata (h_s),
        .re    (advance_s),
        .raddr (s1_addr_r),
        .rdata (line_rdata_s)
    );

    // Two-stage pipeline and output register; everything moves together on advance_s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_odd_col_r <= 1'b0;
            s1_odd_row_r <= 1'b0;
            s1_data_r    <= '0;
            s1_addr_r    <= '0;
            s2_emit_r    <= 1'b0;
            s2_h_r       <= '0;
            m_valid_r    <= 1'b0;
            m_data_r     <= '0;
        end else if (advance_s) begin
            s1_valid_r   <= accept_s;
            s1_odd_col_r <= c_r[0];
            s1_odd_row_r <= r_r[0];
            s1_data_r    <= S_Data;
            s1_addr_r    <= lb_addr_s;
            s2_emit_r    <= s1_valid_r && s1_odd_col_r && s1_odd_row_r;
            s2_h_r       <= h_s;
            m_valid_r    <= s2_emit_r;
            if (s2_emit_r) begin
                m_data_r <= v_s;
            end
        end
    end

    // Output position counters and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oc_r            <= '0;
            ocol_r          <= '0;
            orow_r          <= '0;
            pool_complete_r <= 1'b0;
        end else begin
            pool_complete_r <= done_s;
            if (Next_Reg) begin
                oc_r   <= '0;
                ocol_r <= '0;
                orow_r <= '0;
            end else if (m_valid_r && M_Ready) begin
                if (oc_r == g_cfg_r - 10'd1) begin
                    oc_r <= '0;
                    if (ocol_r == half_w_s - 11'd1) begin
                        ocol_r <= '0;
                        orow_r <= (orow_r == half_h_s - 11'd1) ? 11'd0 : orow_r + 11'd1;
                    end else begin
                        ocol_r <= ocol_r + 11'd1;
                    end
                end else begin
                    oc_r <= oc_r + 10'd1;
                end
            end
        end
    end

    assign M_Data        = m_data_r;
    assign M_Valid       = m_valid_r;
    assign Pool_Complete = pool_complete_r;
    assign Last_Pool     = m_valid_r && (oc_r == g_cfg_r - 10'd1) &&
                           (ocol_r == half_w_s - 11'd1) && (orow_r == half_h_s - 11'd1);
endmodule

// File: tb/tb_maxpool_downsampling.sv
// Randomized bench for maxpool_downsampling against a 2x2 window-max reference model.
module tb_maxpool_downsampling;
    logic         clk = 1'b0;
    logic         rst, Start, Next_Reg;
    logic [10:0]  row_cfg, col_cfg;
    logic [9:0]   ch_cfg;
    logic [255:0] s_data, m_data;
    logic         s_valid, s_ready, m_valid, m_ready, last_pool, pool_complete;

    int n_checks = 0;
    int n_errors = 0;
    logic [255:0] in_q[$];
    logic [255:0] exp_q[$];

    always #5 clk = ~clk;

    maxpool_downsampling dut (
        .clk                (clk),
        .rst                (rst),
        .Start              (Start),
        .Next_Reg           (Next_Reg),
        .Row_Num_In_REG     (row_cfg),
        .Col_Num_In_REG     (col_cfg),
        .Channel_In_Num_REG (ch_cfg),
        .S_Data             (s_data),
        .S_Valid            (s_valid),
        .S_Ready            (s_ready),
        .M_Data             (m_data),
        .M_Valid            (m_valid),
        .M_Ready            (m_ready),
        .Last_Pool          (last_pool),
        .Pool_Complete      (pool_complete)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lane_val(input logic [255:0] beat, input int l);
        logic signed [15:0] x;
        x = beat[l*16 +: 16];
        return int'(x);
    endfunction

    // Input map in stream order: row, column, group innermost.
    task automatic build_map(input int h, input int w, input int g, input int mode);
        in_q.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                for (int gi = 0; gi < g; gi++) begin
                    logic [255:0] b;
                    b = '0;
                    case (mode)
                        0:       b[15:0] = 16'(r*w + c);
                        1:       b[15:0] = 16'(-(r*w + c) - 1);
                        2:       b[15:0] = 16'(r*w + c + 100*gi);
                        default: for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom();
                    endcase
                    in_q.push_back(b);
                end
    endtask

    // Each output lane is the signed maximum of its 2x2 input window.
    task automatic build_expected(input int h, input int w, input int g);
        exp_q.delete();
        for (int orow = 0; orow < h/2; orow++)
            for (int ocol = 0; ocol < w/2; ocol++)
                for (int gi = 0; gi < g; gi++) begin
                    logic [255:0] b;
                    b = '0;
                    for (int l = 0; l < 16; l++) begin
                        int best;
                        best = -1000000;
                        for (int dr = 0; dr < 2; dr++)
                            for (int dc = 0; dc < 2; dc++) begin
                                int v;
                                v = lane_val(in_q[((2*orow + dr)*w + 2*ocol + dc)*g + gi], l);
                                if (v > best) best = v;
                            end
                        b[l*16 +: 16] = best[15:0];
                    end
                    exp_q.push_back(b);
                end
    endtask

    task automatic run_map(input string name, input int h, input int w, input int g,
                           input int mode, input int vpct, input int rpct, input int abort_at);
        int idx, k, cyc, stalls, d, n_in, nexp, budget;
        logic stall_prev;
        logic [255:0] held;
        build_map(h, w, g, mode);
        build_expected(h, w, g);
        n_in = in_q.size();
        nexp = exp_q.size();
        budget = 30*n_in + 200;
        idx = 0; k = 0; cyc = 0; stalls = 0; stall_prev = 1'b0; held = '0;

        @(posedge clk); #1;
        row_cfg = 11'(h); col_cfg = 11'(w); ch_cfg = 10'(g*16); Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        row_cfg = 11'($urandom); col_cfg = 11'($urandom); ch_cfg = 10'($urandom);
        s_valid = (n_in > 0) && ($urandom_range(99) < vpct);
        s_data  = in_q[0];
        m_ready = ($urandom_range(99) < rpct);

        while (1) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                check_eq({name, "_hold_valid"}, 256'(m_valid), 256'(1));
                check_eq({name, "_hold_data"}, m_data, held);
            end
            if (m_valid && m_ready) begin
                if (k < nexp) begin
                    check_eq({name, "_beat"}, m_data, exp_q[k]);
                    check_eq({name, "_last"}, 256'(last_pool), 256'(k == nexp - 1));
                end else begin
                    check_eq({name, "_extra_beat"}, 256'(m_valid), 256'(0));
                end
                k++;
            end
            stall_prev = m_valid && !m_ready;
            held = m_data;
            if (s_valid && !s_ready) stalls++;
            if (s_valid && s_ready) idx++;
            if (abort_at >= 0 && idx >= abort_at) break;
            if ((idx >= n_in && k >= nexp) || cyc >= budget) break;
            @(posedge clk); #1;
            s_valid = (idx < n_in) && ($urandom_range(99) < vpct);
            if (idx < n_in) s_data = in_q[idx];
            m_ready = ($urandom_range(99) < rpct);
        end

        if (abort_at >= 0) begin
            rst = 1'b1;
            s_valid = 1'b0;
            @(negedge clk);
            check_eq({name, "_rst_sready"}, 256'(s_ready), 256'(0));
            check_eq({name, "_rst_mvalid"}, 256'(m_valid), 256'(0));
            check_eq({name, "_rst_mdata"}, m_data, 256'(0));
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end

        check_eq({name, "_accepted"}, 256'(idx), 256'(n_in));
        check_eq({name, "_beats"}, 256'(k), 256'(nexp));
        if (vpct == 100 && rpct == 100) check_eq({name, "_in_stalls"}, 256'(stalls), 256'(0));
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        d = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pool_complete) begin
                d = i;
                break;
            end
        end
        check_eq({name, "_complete_seen"}, 256'(d != 0), 256'(1));
        if (nexp > 0 && h % 2 == 0 && w % 2 == 0) check_eq({name, "_complete_delay"}, 256'(d), 256'(1));
        @(negedge clk);
        check_eq({name, "_complete_pulse"}, 256'(pool_complete), 256'(0));
        check_eq({name, "_idle_mvalid"}, 256'(m_valid), 256'(0));
    endtask

    initial begin
        rst = 1'b1; Start = 1'b0; Next_Reg = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        row_cfg = '0; col_cfg = '0; ch_cfg = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_sready", 256'(s_ready), 256'(0));
        check_eq("reset_mvalid", 256'(m_valid), 256'(0));
        check_eq("reset_mdata", m_data, 256'(0));
        check_eq("reset_complete", 256'(pool_complete), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_map("ramp4x4", 4, 4, 1, 0, 100, 100, -1);
        run_map("neg4x4", 4, 4, 1, 1, 100, 100, -1);
        run_map("grp2", 4, 4, 2, 2, 100, 100, -1);
        @(posedge clk); #1;
        Next_Reg = 1'b1;
        @(posedge clk); #1;
        Next_Reg = 1'b0;
        run_map("odd5x5", 5, 5, 1, 3, 100, 100, -1);
        run_map("rnd8x8", 8, 8, 4, 3, 70, 50, -1);
        run_map("rnd6x7", 6, 7, 3, 3, 80, 80, -1);
        run_map("row1", 1, 4, 1, 3, 100, 100, -1);
        run_map("abort", 4, 4, 1, 0, 100, 100, 6);
        run_map("after_rst", 4, 4, 1, 0, 100, 100, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
